// File: rtl/buf_col_sched_pkg.sv
// Shared definitions for the buffer column scheduler: FSM encoding,
// buffer/window geometry and the modulo column increment.
package buf_col_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int BUF_COLS = 4;
  localparam int WIN_COLS = 3;
  localparam int COL_W    = $clog2(BUF_COLS);

  // Buffer columns form a ring, so the increment wraps naturally at BUF_COLS.
  function automatic logic [COL_W-1:0] col_inc(input logic [COL_W-1:0] col);
    return col + COL_W'(1);
  endfunction

endpackage

// File: rtl/buf_col_sched_col_counter.sv
// Holds the buffer column currently being written; loaded only on
// column completion by the scheduler.
module reg_buf_col_counter
  import buf_col_sched_pkg::*;
(
  input  logic             CLK,
  input  logic             RST_ASYNC_N,
  input  logic             we_i,
  input  logic [COL_W-1:0] d_i,
  output logic [COL_W-1:0] q_o
);

  logic [COL_W-1:0] col_q;

  // Column register with load enable.
  always_ff @(posedge CLK or negedge RST_ASYNC_N) begin
    if (!RST_ASYNC_N) begin
      col_q <= '0;
    end else if (we_i) begin
      col_q <= d_i;
    end else begin
      col_q <= col_q;
    end
  end

  assign q_o = col_q;

endmodule

// File: rtl/buf_col_sched.sv
// Schedules pixel writes into a 4-column ring buffer and hands out
// 3-column windows, stalling input when a finished column has no free slot.
module buf_col_sched
  import buf_col_sched_pkg::*;
#(
  parameter int ROWS = 8,
  parameter int COLS = 16
) (
  input  logic                    CLK,
  input  logic                    RST_ASYNC_N,
  input  logic                    START,
  input  logic                    PIX_VALID,
  output logic                    PIX_READY,
  output logic                    BUF_WE,
  output logic [$clog2(ROWS)-1:0] BUF_ROW,
  output logic [COL_W-1:0]        BUF_COL,
  output logic                    COL_REG_WE,
  output logic [COL_W-1:0]        COL_REG_D,
  output logic                    WIN_VALID,
  input  logic                    WIN_READY,
  output logic [COL_W-1:0]        WIN_COL,
  output logic                    BUSY,
  output logic                    DONE
);

  localparam int ROW_W = $clog2(ROWS);
  localparam int CNT_W = $clog2(COLS + 1);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(ROWS - 1);
  localparam logic [CNT_W-1:0] CNT_ALL   = CNT_W'(COLS);
  localparam logic [CNT_W-1:0] CNT_FIRST = CNT_W'(WIN_COLS - 1);

  state_t           state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             win_valid_q, win_valid_d;
  logic [COL_W-1:0] win_col_q, win_col_d;
  logic             pend_q, pend_d;

  logic             pix_ready_s;
  logic             accept_s;
  logic             col_done_s;
  logic             hs_s;
  logic [COL_W-1:0] buf_col_s;

  reg_buf_col_counter u_col_reg (
    .CLK         (CLK),
    .RST_ASYNC_N (RST_ASYNC_N),
    .we_i        (col_done_s),
    .d_i         (COL_REG_D),
    .q_o         (buf_col_s)
  );

  // Input is refused while a completed column waits for a window slot.
  assign pix_ready_s = ((state_q == ST_FILL) || (state_q == ST_RUN)) &&
                       (cnt_q != CNT_ALL) && !pend_q;
  assign accept_s    = PIX_VALID && pix_ready_s;
  assign col_done_s  = accept_s && (row_q == ROW_LAST);
  assign hs_s        = win_valid_q && WIN_READY;

  // Next-state for FSM, row/column counters and window tracking.
  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    cnt_d       = cnt_q;
    win_valid_d = win_valid_q;
    win_col_d   = win_col_q;
    pend_d      = pend_q;

    if (accept_s) begin
      if (col_done_s) begin
        row_d = '0;
        cnt_d = cnt_q + CNT_W'(1);
      end else begin
        row_d = row_q + ROW_W'(1);
      end
    end else begin
      row_d = row_q;
    end

    // A window-forming completion racing a handshake simply replaces the
    // consumed window, so no pending slot is needed.
    if (col_done_s && (cnt_q >= CNT_FIRST)) begin
      if (!win_valid_q) begin
        win_valid_d = 1'b1;
      end else if (hs_s) begin
        win_col_d = col_inc(win_col_q);
      end else begin
        pend_d = 1'b1;
      end
    end else if (hs_s) begin
      win_col_d = col_inc(win_col_q);
      if (pend_q) begin
        pend_d = 1'b0;
      end else begin
        win_valid_d = 1'b0;
      end
    end else begin
      win_col_d = win_col_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (START) begin
          state_d   = ST_FILL;
          row_d     = '0;
          cnt_d     = '0;
          win_col_d = buf_col_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FILL: begin
        if (col_done_s && (cnt_q == CNT_FIRST)) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_FILL;
        end
      end
      ST_RUN: begin
        if ((cnt_q == CNT_ALL) && !win_valid_q && !pend_q) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers.
  always_ff @(posedge CLK or negedge RST_ASYNC_N) begin
    if (!RST_ASYNC_N) begin
      state_q     <= ST_IDLE;
      row_q       <= '0;
      cnt_q       <= '0;
      win_valid_q <= 1'b0;
      win_col_q   <= '0;
      pend_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      cnt_q       <= cnt_d;
      win_valid_q <= win_valid_d;
      win_col_q   <= win_col_d;
      pend_q      <= pend_d;
    end
  end

  assign PIX_READY  = pix_ready_s;
  assign BUF_WE     = accept_s;
  assign BUF_ROW    = row_q;
  assign BUF_COL    = buf_col_s;
  assign COL_REG_WE = col_done_s;
  assign COL_REG_D  = col_done_s ? col_inc(buf_col_s) : '0;
  assign WIN_VALID  = win_valid_q;
  assign WIN_COL    = win_col_q;
  assign BUSY       = (state_q != ST_IDLE);
  assign DONE       = (state_q == ST_DONE);

endmodule

// File: tb/tb_buf_col_sched.sv
// Directed bench for buf_col_sched: ROWS=4 with COLS=5 and COLS=6 instances.
module tb_buf_col_sched;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic rst_n = 1'b0;
  logic start5 = 1'b0, start6 = 1'b0, pix_valid = 1'b0, win_ready = 1'b0;
  logic sel6 = 1'b0;

  logic pix_ready5, buf_we5, col_we5, win_valid5, busy5, done5;
  logic [1:0] buf_row5, buf_col5, col_d5, win_col5;
  logic pix_ready6, buf_we6, col_we6, win_valid6, busy6, done6;
  logic [1:0] buf_row6, buf_col6, col_d6, win_col6;

  buf_col_sched #(.ROWS(4), .COLS(5)) dut5 (
    .CLK(CLK), .RST_ASYNC_N(rst_n), .START(start5), .PIX_VALID(pix_valid),
    .PIX_READY(pix_ready5), .BUF_WE(buf_we5), .BUF_ROW(buf_row5), .BUF_COL(buf_col5),
    .COL_REG_WE(col_we5), .COL_REG_D(col_d5), .WIN_VALID(win_valid5),
    .WIN_READY(win_ready), .WIN_COL(win_col5), .BUSY(busy5), .DONE(done5)
  );

  buf_col_sched #(.ROWS(4), .COLS(6)) dut6 (
    .CLK(CLK), .RST_ASYNC_N(rst_n), .START(start6), .PIX_VALID(pix_valid),
    .PIX_READY(pix_ready6), .BUF_WE(buf_we6), .BUF_ROW(buf_row6), .BUF_COL(buf_col6),
    .COL_REG_WE(col_we6), .COL_REG_D(col_d6), .WIN_VALID(win_valid6),
    .WIN_READY(win_ready), .WIN_COL(win_col6), .BUSY(busy6), .DONE(done6)
  );

  logic m_buf_we, m_col_we, m_win_valid, m_done;
  logic [1:0] m_buf_col, m_col_d, m_win_col;
  assign m_buf_we    = sel6 ? buf_we6    : buf_we5;
  assign m_col_we    = sel6 ? col_we6    : col_we5;
  assign m_win_valid = sel6 ? win_valid6 : win_valid5;
  assign m_done      = sel6 ? done6      : done5;
  assign m_buf_col   = sel6 ? buf_col6   : buf_col5;
  assign m_col_d     = sel6 ? col_d6     : col_d5;
  assign m_win_col   = sel6 ? win_col6   : win_col5;

  logic [13:0] all5, all6;
  assign all5 = {pix_ready5, buf_we5, buf_row5, buf_col5, col_we5, col_d5, win_valid5, win_col5, busy5, done5};
  assign all6 = {pix_ready6, buf_we6, buf_row6, buf_col6, col_we6, col_d6, win_valid6, win_col6, busy6, done6};

  int total = 0;
  int bad = 0;
  int acc, done_cnt;
  int we_acc_q[$], bc_q[$], cd_q[$], wc_q[$];

  task automatic clear_mon();
    acc = 0;
    done_cnt = 0;
    we_acc_q.delete();
    bc_q.delete();
    cd_q.delete();
    wc_q.delete();
  endtask

  // One clock: sample the selected DUT mid-cycle, then advance past the edge.
  task automatic cycle();
    #2;
    if (m_buf_we) acc++;
    if (m_col_we) begin
      we_acc_q.push_back(acc);
      bc_q.push_back(int'(m_buf_col));
      cd_q.push_back(int'(m_col_d));
    end
    if (m_win_valid && win_ready) wc_q.push_back(int'(m_win_col));
    if (m_done) begin
      done_cnt++;
      start5 = 1'b0;
      start6 = 1'b0;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic run_until_done(input int budget);
    for (int i = 0; i < budget && done_cnt == 0; i++) cycle();
    repeat (3) cycle();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start5 = 1'b0;
    start6 = 1'b0;
    pix_valid = 1'b0;
    win_ready = 1'b0;
    @(posedge CLK);
    #1;
    rst_n = 1'b1;
    clear_mon();
  endtask

  task automatic test_reset();
    @(posedge CLK);
    #1;
    total++; if (all5 !== 14'd0) begin bad++; $display("FAIL reset_out5: got %b want 0", all5); end
    total++; if (all6 !== 14'd0) begin bad++; $display("FAIL reset_out6: got %b want 0", all6); end
    start5 = 1'b1; start6 = 1'b1; pix_valid = 1'b1; win_ready = 1'b1;
    @(posedge CLK);
    #1;
    total++; if (all5 !== 14'd0) begin bad++; $display("FAIL reset_held5: got %b want 0", all5); end
    total++; if (all6 !== 14'd0) begin bad++; $display("FAIL reset_held6: got %b want 0", all6); end
    do_reset();
  endtask

  task automatic test_full_frame();
    do_reset();
    sel6 = 1'b0;
    start5 = 1'b1; pix_valid = 1'b1; win_ready = 1'b1;
    run_until_done(200);
    total++; if (acc != 20) begin bad++; $display("FAIL ff_accepts: got %0d want 20", acc); end
    total++; if (we_acc_q.size() != 5) begin bad++; $display("FAIL ff_colwe_n: got %0d want 5", we_acc_q.size()); end
    for (int i = 0; i < 5; i++) begin
      if (i < we_acc_q.size()) begin
        total++; if (we_acc_q[i] != 4 * (i + 1)) begin bad++; $display("FAIL ff_colwe_at[%0d]: got %0d want %0d", i, we_acc_q[i], 4 * (i + 1)); end
        total++; if (bc_q[i] != i % 4) begin bad++; $display("FAIL ff_buf_col[%0d]: got %0d want %0d", i, bc_q[i], i % 4); end
        total++; if (cd_q[i] != (i + 1) % 4) begin bad++; $display("FAIL ff_col_d[%0d]: got %0d want %0d", i, cd_q[i], (i + 1) % 4); end
      end
    end
    total++; if (wc_q.size() != 3) begin bad++; $display("FAIL ff_windows: got %0d want 3", wc_q.size()); end
    for (int i = 0; i < 3; i++) begin
      if (i < wc_q.size()) begin
        total++; if (wc_q[i] != i) begin bad++; $display("FAIL ff_win_col[%0d]: got %0d want %0d", i, wc_q[i], i); end
      end
    end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL ff_done: got %0d want 1", done_cnt); end
    total++; if (busy5 !== 1'b0) begin bad++; $display("FAIL ff_idle: got %0b want 0", busy5); end
  endtask

  task automatic test_backpressure();
    do_reset();
    sel6 = 1'b0;
    start5 = 1'b1; pix_valid = 1'b1; win_ready = 1'b0;
    repeat (40) cycle();
    total++; if (acc != 16) begin bad++; $display("FAIL bp_stall_acc: got %0d want 16", acc); end
    total++; if (pix_ready5 !== 1'b0) begin bad++; $display("FAIL bp_ready: got %0b want 0", pix_ready5); end
    total++; if (win_valid5 !== 1'b1) begin bad++; $display("FAIL bp_win_valid: got %0b want 1", win_valid5); end
    total++; if (win_col5 !== 2'd0) begin bad++; $display("FAIL bp_win_col: got %0d want 0", win_col5); end
    win_ready = 1'b1;
    run_until_done(200);
    total++; if (wc_q.size() != 3) begin bad++; $display("FAIL bp_windows: got %0d want 3", wc_q.size()); end
    for (int i = 0; i < 2; i++) begin
      if (i < wc_q.size()) begin
        total++; if (wc_q[i] != i) begin bad++; $display("FAIL bp_win_seq[%0d]: got %0d want %0d", i, wc_q[i], i); end
      end
    end
    total++; if (acc != 20) begin bad++; $display("FAIL bp_accepts: got %0d want 20", acc); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL bp_done: got %0d want 1", done_cnt); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    sel6 = 1'b0;
    start5 = 1'b1; pix_valid = 1'b1; win_ready = 1'b1;
    for (int i = 0; i < 60 && acc < 14; i++) cycle();
    total++; if (busy5 !== 1'b1) begin bad++; $display("FAIL mr_busy_before: got %0b want 1", busy5); end
    total++; if (buf_col5 !== 2'd3) begin bad++; $display("FAIL mr_col_before: got %0d want 3", buf_col5); end
    #2;
    rst_n = 1'b0;
    start5 = 1'b0;
    #1;
    total++; if (all5 !== 14'd0) begin bad++; $display("FAIL mr_outputs: got %b want 0", all5); end
    @(posedge CLK);
    #1;
    rst_n = 1'b1;
    clear_mon();
    total++; if (buf_col5 !== 2'd0) begin bad++; $display("FAIL mr_buf_col: got %0d want 0", buf_col5); end
    repeat (5) cycle();
    total++; if (acc != 0) begin bad++; $display("FAIL mr_no_restart: got %0d want 0", acc); end
    total++; if (busy5 !== 1'b0) begin bad++; $display("FAIL mr_idle: got %0b want 0", busy5); end
  endtask

  task automatic test_pix_gaps();
    int row_exp;
    logic exp_we;
    do_reset();
    sel6 = 1'b0;
    start5 = 1'b1;
    @(posedge CLK);
    #1;
    start5 = 1'b0;
    row_exp = 0;
    for (int i = 0; i < 10; i++) begin
      exp_we = (i % 2 == 0);
      pix_valid = exp_we;
      #2;
      total++; if (buf_we5 !== exp_we) begin bad++; $display("FAIL gap_we[%0d]: got %0b want %0b", i, buf_we5, exp_we); end
      total++; if (int'(buf_row5) != row_exp) begin bad++; $display("FAIL gap_row[%0d]: got %0d want %0d", i, buf_row5, row_exp); end
      if (exp_we) row_exp = (row_exp + 1) % 4;
      @(posedge CLK);
      #1;
    end
    pix_valid = 1'b0;
  endtask

  task automatic test_start_ignored();
    do_reset();
    sel6 = 1'b0;
    start5 = 1'b1; pix_valid = 1'b1; win_ready = 1'b1;
    cycle();
    start5 = 1'b0;
    for (int i = 0; i < 60 && acc < 14; i++) cycle();
    start5 = 1'b1;
    cycle();
    start5 = 1'b0;
    total++; if (busy5 !== 1'b1) begin bad++; $display("FAIL si_busy: got %0b want 1", busy5); end
    total++; if (int'(buf_row5) != acc % 4) begin bad++; $display("FAIL si_row: got %0d want %0d", buf_row5, acc % 4); end
    run_until_done(200);
    total++; if (acc != 20) begin bad++; $display("FAIL si_accepts: got %0d want 20", acc); end
    total++; if (we_acc_q.size() != 5) begin bad++; $display("FAIL si_colwe_n: got %0d want 5", we_acc_q.size()); end
    total++; if (wc_q.size() != 3) begin bad++; $display("FAIL si_windows: got %0d want 3", wc_q.size()); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL si_done: got %0d want 1", done_cnt); end
    total++; if (busy5 !== 1'b0) begin bad++; $display("FAIL si_idle: got %0b want 0", busy5); end
  endtask

  task automatic test_cols6();
    do_reset();
    sel6 = 1'b1;
    start6 = 1'b1; pix_valid = 1'b1; win_ready = 1'b1;
    run_until_done(300);
    total++; if (acc != 24) begin bad++; $display("FAIL c6_accepts: got %0d want 24", acc); end
    total++; if (bc_q.size() != 6) begin bad++; $display("FAIL c6_colwe_n: got %0d want 6", bc_q.size()); end
    for (int i = 0; i < 6; i++) begin
      if (i < bc_q.size()) begin
        total++; if (bc_q[i] != i % 4) begin bad++; $display("FAIL c6_buf_col[%0d]: got %0d want %0d", i, bc_q[i], i % 4); end
      end
    end
    total++; if (wc_q.size() != 4) begin bad++; $display("FAIL c6_windows: got %0d want 4", wc_q.size()); end
    for (int i = 0; i < 4; i++) begin
      if (i < wc_q.size()) begin
        total++; if (wc_q[i] != i) begin bad++; $display("FAIL c6_win_col[%0d]: got %0d want %0d", i, wc_q[i], i); end
      end
    end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL c6_done: got %0d want 1", done_cnt); end
    total++; if (busy6 !== 1'b0) begin bad++; $display("FAIL c6_idle: got %0b want 0", busy6); end
    sel6 = 1'b0;
  endtask

  initial begin
    clear_mon();
    test_reset();
    test_full_frame();
    test_backpressure();
    test_mid_reset();
    test_pix_gaps();
    test_start_ignored();
    test_cols6();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
